tlul_sync_fifo: RTL and testbench
=================================

# tlul_sync_fifo

Single-clock TL-UL buffering stage that sits directly upstream of the register adapter: it decouples the crossbar/host side from the device side of a peripheral. It holds a parameterisable number of A-channel requests and D-channel responses in two independent FIFOs. This absorbs backpressure from the register interface (`busy` stalls, one-outstanding behaviour) and breaks the combinational ready paths between host and device.

## Interface
- `ReqDepth`, 2: A-channel FIFO entries; legal range 1..16 (elaboration assertion).
- `RspDepth`, 2: D-channel FIFO entries; legal range 1..16 (elaboration assertion).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `tl_h_i` in `tl_h2d_t`: host-side request; carries `a_*` and `d_ready`.
- `tl_h_o` out `tl_d2h_t`: host-side response; carries `d_*` and `a_ready`.
- `tl_d_o` out `tl_h2d_t`: device-side request toward the register adapter.
- `tl_d_i` in `tl_d2h_t`: device-side response from the register adapter.
- `req_cnt_o` out `$clog2(ReqDepth+1)`: A FIFO occupancy.
- `rsp_cnt_o` out `$clog2(RspDepth+1)`: D FIFO occupancy.

## Operation
- **A path.**
  - Push on `tl_h_i.a_valid & tl_h_o.a_ready`.
  - Pop on `tl_d_o.a_valid & tl_d_i.a_ready`.
  - Stored payload: every `a_*` field except `a_valid` (opcode, param, size, source, address, mask, data, user).
- **D path.**
  - Push on `tl_d_i.d_valid & tl_d_o.d_ready`.
  - Pop on `tl_h_o.d_valid & tl_h_i.d_ready`.
  - Stored payload: every `d_*` field except `d_valid`.
- **Ready/valid wiring.**
  - `tl_h_o.a_ready = !req_full`; `tl_d_o.d_ready = !rsp_full`.
  - `tl_d_o.a_valid = !req_empty`; `tl_h_o.d_valid = !rsp_empty`.
  - Payload outputs are driven from the head entry.
- **Contents are opaque.** The block never modifies payloads, checks integrity or generates errors. Integrity bits in `a_user`/`d_user` pass unchanged.
- **Pointers.**
  - Read and write pointers are `$clog2(Depth)` bits, plus a separate occupancy counter.
  - Pointers wrap from Depth-1 to 0; non-power-of-2 depths use explicit compare-and-clear.
- **Full.**
  - Ready is low, so no push is accepted.
  - A pop in the same cycle frees a slot; ready rises on the next cycle, not combinationally.
- **Empty.** Valid is low; no pop is possible.
- **Simultaneous push and pop (not full, not empty).** Occupancy is unchanged and both pointers advance.
- **Occupancy.** Increments on push only, decrements on pop only. It never exceeds Depth and never goes below 0; assertions cover both bounds.
- **Reset mid-transaction.** All entries are discarded. There is no replay; an in-flight host transaction is lost, matching system reset semantics.
- **Valid stability.** Once `tl_d_o.a_valid` or `tl_h_o.d_valid` is high, it and its payload stay stable until accepted (assertion).

## Timing
- Reset values:
  - `tl_h_o.a_ready`=1, `tl_h_o.d_valid`=0, all other `tl_h_o` fields 0.
  - `tl_d_o.a_valid`=0, `tl_d_o.d_ready`=1, all other `tl_d_o` fields 0.
  - Counters 0; pointers 0.
- Latency without the bypass:
  - Request accepted at cycle N is presented on `tl_d_o` at cycle N+1.
  - Response accepted at cycle M is presented on `tl_h_o` at cycle M+1.
- Throughput: one push and one pop per cycle per channel. Depth 1 therefore yields 50% throughput; depth ≥2 sustains 100%.
- Ready outputs depend only on registered state; there is no combinational input-to-ready path.

## Configuration
- Macro: `TLUL_SYNC_FIFO_BYPASS_EN`.
- Defined (bypass compiled in):
  - When a FIFO is empty and the consumer is ready, the incoming beat passes combinationally to the output in the same cycle (zero latency) and is not stored.
  - When empty and the consumer is not ready, the beat is stored normally.
  - Ready outputs remain registered-only.
- Undefined: strict 1-cycle minimum latency on both paths, as described in Timing.

## Structure
- Shared package `tlul_pkg` owns:
  - typedef `tl_a_pld_t`: A payload struct without valid/ready.
  - typedef `tl_d_pld_t`: D payload struct without valid/ready.
  - constant `TlFifoMaxDepth = 16`.
- Sub-module `tlul_fifo_core`:
  - Generic synchronous FIFO, parameterised by Width, Depth and the bypass option.
  - Ports: wvalid/wready/wdata, rvalid/rready/rdata, cnt.
  - Instantiated twice, once per channel.

## Test plan
- **Reset:** hold `rst_ni`=0 → `tl_h_o.a_ready`=1, `tl_d_o.a_valid`=0, `tl_d_o.d_ready`=1, counters 0.
- **Single Get:** source 0x5 at address 0x10, device ready → `tl_d_o.a_valid` at N+1 (N with bypass) with source 0x5. Device responds with AccessAckData, data 0xDEADBEEF → host sees the same data at M+1.
- **Fill to full:** ReqDepth=2, device `a_ready`=0, three back-to-back Puts → first two accepted, `req_cnt_o`=2, `a_ready`=0 on the third.
- **Full plus pop:** with the FIFO full, raise device `a_ready` for one cycle → pop occurs; `a_ready` rises on the next cycle; order is preserved (sources 1, 2).
- **Wrap:** ReqDepth=3, 10 streaming Puts with device always ready → addresses 0x0..0x24 emerge in order; counter never exceeds 3.
- **Reset mid-operation:** with 2 entries queued, assert `rst_ni` → outputs return to reset values and no stale beat appears after release.

Source files
------------

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL types for the buffering stage.
//   tl_h2d_t   host->device channel (A request fields + d_ready)
//   tl_d2h_t   device->host channel (D response fields + a_ready)
//   tl_a_pld_t A payload as stored in the request FIFO (no handshake bits)
//   tl_d_pld_t D payload as stored in the response FIFO (no handshake bits)
//   TlFifoMaxDepth  largest supported FIFO depth
package tlul_pkg;

  localparam int unsigned TlFifoMaxDepth = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
  } tl_a_pld_t;

  typedef struct packed {
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
  } tl_d_pld_t;

  function automatic tl_a_pld_t a_pld_of(tl_h2d_t t);
    tl_a_pld_t p;
    p.a_opcode  = t.a_opcode;
    p.a_param   = t.a_param;
    p.a_size    = t.a_size;
    p.a_source  = t.a_source;
    p.a_address = t.a_address;
    p.a_mask    = t.a_mask;
    p.a_data    = t.a_data;
    p.a_user    = t.a_user;
    return p;
  endfunction

  function automatic tl_d_pld_t d_pld_of(tl_d2h_t t);
    tl_d_pld_t p;
    p.d_opcode = t.d_opcode;
    p.d_param  = t.d_param;
    p.d_size   = t.d_size;
    p.d_source = t.d_source;
    p.d_sink   = t.d_sink;
    p.d_data   = t.d_data;
    p.d_user   = t.d_user;
    p.d_error  = t.d_error;
    return p;
  endfunction

endpackage

// File: rtl/tlul_fifo_core.sv
// tlul_fifo_core: generic single-clock valid/ready FIFO.
// Parameters: Width (payload bits), Depth (1..TlFifoMaxDepth), BypassEn
// (empty FIFO forwards a beat combinationally when the reader is ready).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   wvalid_i/wready_o/wdata_i  write side; wready_o is registered-state only
//   rvalid_o/rready_i/rdata_o  read side; rdata_o is zero while nothing valid
//   cnt_o                  number of stored entries
import tlul_pkg::*;

module tlul_fifo_core #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Depth    = 2,
  parameter bit          BypassEn = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  input  logic [Width-1:0]           wdata_i,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] cnt_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  if (Depth < 1 || Depth > TlFifoMaxDepth) begin : gen_depth_err
    $error("tlul_fifo_core: Depth out of range 1..16");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty, full, bypass, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DepthCnt);

  // A bypassed beat goes straight to the reader and never occupies a slot.
  assign bypass = BypassEn && empty && wvalid_i && rready_i;
  assign push   = wvalid_i && !full && !bypass;
  assign pop    = !empty && rready_i;

  assign wready_o = !full;
  assign rvalid_o = !empty || (BypassEn && wvalid_i);
  assign cnt_o    = cnt_q;

  always_comb begin
    rdata_o = '0;
    if (!empty) begin
      rdata_o = mem_q[rptr_q];
    end else if (BypassEn && wvalid_i) begin
      rdata_o = wdata_i;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset: the occupancy counter alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= DepthCnt);
  a_no_ovf:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(full && push));
  a_no_udf:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(empty && pop));
  a_stable:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                              (rvalid_o && !rready_i) |=> (rvalid_o && $stable(rdata_o)));

endmodule

// File: rtl/tlul_sync_fifo.sv
// tlul_sync_fifo: TL-UL request/response buffering stage in front of the
// register adapter. One FIFO per channel; payloads pass through untouched.
// Compile-time option: TLUL_SYNC_FIFO_BYPASS_EN enables zero-latency
// pass-through when a FIFO is empty and its consumer is ready.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   tl_h_i/tl_h_o  host side (A in, D out, a_ready out, d_ready in)
//   tl_d_o/tl_d_i  device side (A out, D in, d_ready out, a_ready in)
//   req_cnt_o      A FIFO occupancy
//   rsp_cnt_o      D FIFO occupancy
import tlul_pkg::*;

module tlul_sync_fifo #(
  parameter int unsigned ReqDepth = 2,
  parameter int unsigned RspDepth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  tl_h2d_t                       tl_h_i,
  output tl_d2h_t                       tl_h_o,
  output tl_h2d_t                       tl_d_o,
  input  tl_d2h_t                       tl_d_i,
  output logic [$clog2(ReqDepth+1)-1:0] req_cnt_o,
  output logic [$clog2(RspDepth+1)-1:0] rsp_cnt_o
);

`ifdef TLUL_SYNC_FIFO_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  tl_a_pld_t req_wdata, req_rdata;
  tl_d_pld_t rsp_wdata, rsp_rdata;
  logic      req_wready, req_rvalid, rsp_wready, rsp_rvalid;

  assign req_wdata = a_pld_of(tl_h_i);
  assign rsp_wdata = d_pld_of(tl_d_i);

  tlul_fifo_core #(
    .Width    ($bits(tl_a_pld_t)),
    .Depth    (ReqDepth),
    .BypassEn (BypassEn)
  ) u_req_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (tl_h_i.a_valid),
    .wready_o (req_wready),
    .wdata_i  (req_wdata),
    .rvalid_o (req_rvalid),
    .rready_i (tl_d_i.a_ready),
    .rdata_o  (req_rdata),
    .cnt_o    (req_cnt_o)
  );

  tlul_fifo_core #(
    .Width    ($bits(tl_d_pld_t)),
    .Depth    (RspDepth),
    .BypassEn (BypassEn)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (tl_d_i.d_valid),
    .wready_o (rsp_wready),
    .wdata_i  (rsp_wdata),
    .rvalid_o (rsp_rvalid),
    .rready_i (tl_h_i.d_ready),
    .rdata_o  (rsp_rdata),
    .cnt_o    (rsp_cnt_o)
  );

  always_comb begin
    tl_d_o           = '0;
    tl_d_o.a_valid   = req_rvalid;
    tl_d_o.a_opcode  = req_rdata.a_opcode;
    tl_d_o.a_param   = req_rdata.a_param;
    tl_d_o.a_size    = req_rdata.a_size;
    tl_d_o.a_source  = req_rdata.a_source;
    tl_d_o.a_address = req_rdata.a_address;
    tl_d_o.a_mask    = req_rdata.a_mask;
    tl_d_o.a_data    = req_rdata.a_data;
    tl_d_o.a_user    = req_rdata.a_user;
    tl_d_o.d_ready   = rsp_wready;
  end

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.d_valid  = rsp_rvalid;
    tl_h_o.d_opcode = rsp_rdata.d_opcode;
    tl_h_o.d_param  = rsp_rdata.d_param;
    tl_h_o.d_size   = rsp_rdata.d_size;
    tl_h_o.d_source = rsp_rdata.d_source;
    tl_h_o.d_sink   = rsp_rdata.d_sink;
    tl_h_o.d_data   = rsp_rdata.d_data;
    tl_h_o.d_user   = rsp_rdata.d_user;
    tl_h_o.d_error  = rsp_rdata.d_error;
    tl_h_o.a_ready  = req_wready;
  end

endmodule

// File: tb/tb_tlul_sync_fifo.sv
import tlul_pkg::*;

module tb_tlul_sync_fifo;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t h_i, d_o, h3_i, d3_o;
  tl_d2h_t h_o, d_i, h3_o, d3_i;
  logic [1:0] rc, sc, rc3, sc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlul_sync_fifo #(.ReqDepth(2), .RspDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o),
    .tl_d_o(d_o), .tl_d_i(d_i), .req_cnt_o(rc), .rsp_cnt_o(sc)
  );

  tlul_sync_fifo #(.ReqDepth(3), .RspDepth(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h3_i), .tl_h_o(h3_o),
    .tl_d_o(d3_o), .tl_d_i(d3_i), .req_cnt_o(rc3), .rsp_cnt_o(sc3)
  );

  // Payload fields other than source/address/data are derived from the
  // source so that every stored bit is exercised on the way through.
  function automatic tl_h2d_t mk_h2d(logic v, logic [7:0] src, logic [31:0] addr, logic dr);
    tl_h2d_t t;
    t = '0;
    if (v) begin
      t.a_valid   = 1'b1;
      t.a_opcode  = (src == 8'h05) ? Get : PutFullData;
      t.a_param   = 3'd0;
      t.a_size    = 2'd2;
      t.a_source  = src;
      t.a_address = addr;
      t.a_mask    = ~src[3:0];
      t.a_data    = {addr[15:0], 8'h5A, src};
      t.a_user    = {8'hA5, src};
    end
    t.d_ready = dr;
    return t;
  endfunction

  function automatic tl_d2h_t mk_d2h(logic v, logic [7:0] src, logic [31:0] data, logic ar);
    tl_d2h_t t;
    t = '0;
    if (v) begin
      t.d_valid  = 1'b1;
      t.d_opcode = AccessAckData;
      t.d_param  = 3'd0;
      t.d_size   = 2'd2;
      t.d_source = src;
      t.d_sink   = 1'b1;
      t.d_data   = data;
      t.d_user   = {8'h3C, src};
      t.d_error  = src[0];
    end
    t.a_ready = ar;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic hav; logic [7:0] hsrc; logic [31:0] haddr; logic dar;
    logic ddv; logic [7:0] dsrc; logic [31:0] ddata; logic hdr;
    logic e_ar; logic e_av; logic [7:0] e_asrc; logic [31:0] e_aaddr; logic [1:0] e_rc;
    logic e_dr; logic e_dv; logic [7:0] e_dsrc; logic [31:0] e_ddata; logic [1:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic hav, input logic [7:0] hsrc, input logic [31:0] haddr, input logic dar,
    input logic ddv, input logic [7:0] dsrc, input logic [31:0] ddata, input logic hdr,
    input logic e_ar, input logic e_av, input logic [7:0] e_asrc, input logic [31:0] e_aaddr,
    input logic [1:0] e_rc, input logic e_dr, input logic e_dv, input logic [7:0] e_dsrc,
    input logic [31:0] e_ddata, input logic [1:0] e_sc);
    vec_t v;
    v.hav = hav; v.hsrc = hsrc; v.haddr = haddr; v.dar = dar;
    v.ddv = ddv; v.dsrc = dsrc; v.ddata = ddata; v.hdr = hdr;
    v.e_ar = e_ar; v.e_av = e_av; v.e_asrc = e_asrc; v.e_aaddr = e_aaddr; v.e_rc = e_rc;
    v.e_dr = e_dr; v.e_dv = e_dv; v.e_dsrc = e_dsrc; v.e_ddata = e_ddata; v.e_sc = e_sc;
    vecs.push_back(v);
  endtask

  initial begin
    int sent, recv;
    logic dar3;

    h_i  = mk_h2d(0, 0, 0, 0);
    d_i  = mk_d2h(0, 0, 0, 0);
    h3_i = mk_h2d(0, 0, 0, 0);
    d3_i = mk_d2h(0, 0, 0, 0);

    // Inputs per cycle, then expected outputs as seen during that cycle
    // (before the edge that acts on the inputs).
    //      hav hsrc haddr   dar ddv dsrc ddata         hdr  ar av asrc aaddr  rc  dr dv dsrc ddata        sc
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // idle
    add_vec(1,  5,   'h10,   1,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // Get accepted
    add_vec(0,  0,   0,      1,  0,  0,   0,            0,   1, 1, 5,   'h10,  1,  1, 0, 0,   0,           0); // presented N+1
    add_vec(0,  0,   0,      0,  1,  5,   'hDEADBEEF,   1,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // response in
    add_vec(0,  0,   0,      0,  0,  0,   0,            1,   1, 0, 0,   0,     0,  1, 1, 5,   'hDEADBEEF,  1); // host sees M+1
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0);
    add_vec(1,  1,   'h100,  0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // fill
    add_vec(1,  2,   'h104,  0,  0,  0,   0,            0,   1, 1, 1,   'h100, 1,  1, 0, 0,   0,           0);
    add_vec(1,  3,   'h108,  0,  0,  0,   0,            0,   0, 1, 1,   'h100, 2,  1, 0, 0,   0,           0); // third refused
    add_vec(1,  3,   'h108,  1,  0,  0,   0,            0,   0, 1, 1,   'h100, 2,  1, 0, 0,   0,           0); // pop while full
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 1, 2,   'h104, 1,  1, 0, 0,   0,           0); // ready rises late
    add_vec(0,  0,   0,      1,  0,  0,   0,            0,   1, 1, 2,   'h104, 1,  1, 0, 0,   0,           0);
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0);
    add_vec(0,  0,   0,      0,  1,  'hA, 'h11,         0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // D fill
    add_vec(0,  0,   0,      0,  1,  'hB, 'h22,         0,   1, 0, 0,   0,     0,  1, 1, 'hA, 'h11,        1);
    add_vec(0,  0,   0,      0,  1,  'hC, 'h33,         0,   1, 0, 0,   0,     0,  0, 1, 'hA, 'h11,        2); // D full
    add_vec(0,  0,   0,      0,  0,  0,   0,            1,   1, 0, 0,   0,     0,  0, 1, 'hA, 'h11,        2);
    add_vec(0,  0,   0,      0,  0,  0,   0,            1,   1, 0, 0,   0,     0,  1, 1, 'hB, 'h22,        1);
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0);
    add_vec(1,  7,   'h200,  1,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0); // streaming
    add_vec(1,  8,   'h204,  1,  0,  0,   0,            0,   1, 1, 7,   'h200, 1,  1, 0, 0,   0,           0);
    add_vec(1,  9,   'h208,  1,  0,  0,   0,            0,   1, 1, 8,   'h204, 1,  1, 0, 0,   0,           0);
    add_vec(0,  0,   0,      1,  0,  0,   0,            0,   1, 1, 9,   'h208, 1,  1, 0, 0,   0,           0);
    add_vec(0,  0,   0,      0,  0,  0,   0,            0,   1, 0, 0,   0,     0,  1, 0, 0,   0,           0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_h_o", 128'(h_o), 128'(mk_d2h(0, 0, 0, 1)));
    chk("reset_d_o", 128'(d_o), 128'(mk_h2d(0, 0, 0, 1)));
    chk("reset_cnt", 128'({rc, sc, rc3, sc3}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      h_i = mk_h2d(vecs[i].hav, vecs[i].hsrc, vecs[i].haddr, vecs[i].hdr);
      d_i = mk_d2h(vecs[i].ddv, vecs[i].dsrc, vecs[i].ddata, vecs[i].dar);
      #1;
      chk($sformatf("vec%0d_h_o", i), 128'(h_o),
          128'(mk_d2h(vecs[i].e_dv, vecs[i].e_dsrc, vecs[i].e_ddata, vecs[i].e_ar)));
      chk($sformatf("vec%0d_d_o", i), 128'(d_o),
          128'(mk_h2d(vecs[i].e_av, vecs[i].e_asrc, vecs[i].e_aaddr, vecs[i].e_dr)));
      chk($sformatf("vec%0d_cnt", i), 128'({rc, sc}), 128'({vecs[i].e_rc, vecs[i].e_sc}));
    end

    // Wrap: depth-3 request FIFO, device stalls first then accepts 2 of 3 cycles.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
      @(negedge clk);
      dar3 = (cyc >= 4) && ((cyc % 3) != 0);
      h3_i = mk_h2d(sent < 10, 8'(sent), 32'(sent * 4), 1'b1);
      d3_i = mk_d2h(0, 0, 0, dar3);
      #1;
      if (d3_o.a_valid && dar3) begin
        chk($sformatf("wrap_beat%0d", recv), 128'(d3_o),
            128'(mk_h2d(1, 8'(recv), 32'(recv * 4), 1'b1)));
        recv++;
      end
      chk($sformatf("wrap_cnt_c%0d", cyc), 128'(rc3 <= 2'd3 && sc3 == 2'd0), 128'(1));
      if (h3_i.a_valid && h3_o.a_ready) sent++;
    end
    chk("wrap_all_received", 128'(recv), 128'(10));
    @(negedge clk);
    h3_i = mk_h2d(0, 0, 0, 0);
    d3_i = mk_d2h(0, 0, 0, 0);

    // Reset mid-operation with two requests and two responses queued.
    @(negedge clk);
    h_i = mk_h2d(1, 1, 'h300, 0);
    d_i = mk_d2h(1, 'hD, 'h44, 0);
    @(negedge clk);
    h_i = mk_h2d(1, 2, 'h304, 0);
    d_i = mk_d2h(1, 'hE, 'h55, 0);
    @(negedge clk);
    h_i = mk_h2d(0, 0, 0, 0);
    d_i = mk_d2h(0, 0, 0, 0);
    #1;
    chk("midrst_cnt_before", 128'({rc, sc}), 128'({2'd2, 2'd2}));
    chk("midrst_head_before", 128'(d_o), 128'(mk_h2d(1, 1, 'h300, 0)));
    rst_n = 1'b0;
    #1;
    chk("midrst_h_o", 128'(h_o), 128'(mk_d2h(0, 0, 0, 1)));
    chk("midrst_d_o", 128'(d_o), 128'(mk_h2d(0, 0, 0, 1)));
    chk("midrst_cnt", 128'({rc, sc}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h_i = mk_h2d(0, 0, 0, 1);
    d_i = mk_d2h(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_h_o", k), 128'(h_o), 128'(mk_d2h(0, 0, 0, 1)));
      chk($sformatf("post_rst%0d_d_o", k), 128'(d_o), 128'(mk_h2d(0, 0, 0, 1)));
      chk($sformatf("post_rst%0d_cnt", k), 128'({rc, sc}), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
